// File: rtl/hive_alu_mult_shift.sv
`default_nettype none
// ============================================================================
// Module   : hive_alu_mult_shift
// Purpose  : Fully pipelined multiply / shift / power-of-two unit. One op per
//            cycle is accepted. The result appears at stage 5 and the flags at
//            stage 6. Shifts and POW reuse the single signed multiplier by
//            multiplying with 2^k.
// Ports    : clk_i      - clock, rising edge
//            rst_i      - asynchronous active-high reset
//            ms_sel_i   - op issued this cycle
//            op_i       - 00 MUL_LO, 01 MUL_HI, 10 SHIFT, 11 POW
//            ext_i      - signed MUL_HI / arithmetic right shift
//            a_i, b_i   - operands (SHIFT/POW use b_i[SA_W-1:0])
//            res_ms_5_o - stage-5 result
//            flg_ms_6_o - stage-6 flags {0, ovf, neg, zero}
//            vld_5_o    - stage-5 valid
// Revision : 1.0 - initial release
// ============================================================================
module hive_alu_mult_shift #(
  parameter int ALU_W = 32,
  parameter int FLG_W = 4,
  parameter int SA_W  = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ms_sel_i,
  input  logic [1:0]       op_i,
  input  logic             ext_i,
  input  logic [ALU_W-1:0] a_i,
  input  logic [ALU_W-1:0] b_i,
  output logic [ALU_W-1:0] res_ms_5_o,
  output logic [FLG_W-1:0] flg_ms_6_o,
  output logic             vld_5_o
);

  localparam logic [1:0] OP_MUL_LO = 2'b00;
  localparam logic [1:0] OP_MUL_HI = 2'b01;
  localparam logic [1:0] OP_SHIFT  = 2'b10;
  localparam logic [1:0] OP_POW    = 2'b11;

  // Multiplier geometry: operand B is split into an unsigned low slice and a
  // signed high slice, giving two partial products summed one stage later.
  localparam int MW    = ALU_W + 1;
  localparam int SPL   = (MW + 1) / 2;
  localparam int SPH   = MW - SPL;
  localparam int PPL_W = MW + SPL + 1;
  localparam int PPH_W = MW + SPH;
  localparam int PW    = 2 * MW;

  // ---------------------------------------------------------------- registers
  logic [ALU_W-1:0]        a1_q, b1_q;
  logic [1:0]              op1_q, op2_q, op3_q, op4_q, op5_q;
  logic                    ext1_q, ext2_q, ext3_q, ext4_q, ext5_q;
  logic                    sel1_q, sel2_q, sel3_q, sel4_q, sel5_q;
  logic                    hi2_q, hi3_q, hi4_q;
  logic signed [MW-1:0]    ma2_q, mb2_q;
  logic signed [PPL_W-1:0] ppl3_q;
  logic signed [PPH_W-1:0] pph3_q;
  logic [PW-1:0]           prod4_q;
  logic [ALU_W-1:0]        res5_q;
  logic [ALU_W+1:0]        phi5_q;
  logic [FLG_W-1:0]        flg6_q;

  // ------------------------------------------------- stage 1: operand forming
  logic [MW-1:0]    ma2_d, mb2_d;
  logic             hi2_d;
  logic [ALU_W-1:0] w_pow2;
  logic [MW-1:0]    w_a_ext, w_b_ext;

  // 2^(s mod ALU_W); the low SA_W-1 bits of the shift amount are s mod ALU_W.
  assign w_pow2  = {{(ALU_W-1){1'b0}}, 1'b1} << b1_q[SA_W-2:0];
  assign w_a_ext = {ext1_q & a1_q[ALU_W-1], a1_q};
  assign w_b_ext = {ext1_q & b1_q[ALU_W-1], b1_q};

  always_comb begin
    ma2_d = w_a_ext;
    mb2_d = w_b_ext;
    hi2_d = 1'b0;
    case (op1_q)
      OP_MUL_LO: hi2_d = 1'b0;
      OP_MUL_HI: hi2_d = 1'b1;
      OP_SHIFT: begin
        // Right shifts by k become a multiply by 2^(ALU_W-k) and take the
        // high word; s=-ALU_W multiplies by 1 so the high word is the
        // extension of a_i.
        mb2_d = {1'b0, w_pow2};
        hi2_d = b1_q[SA_W-1];
      end
      OP_POW: begin
        ma2_d = {{(MW-1){1'b0}}, 1'b1};
        mb2_d = b1_q[SA_W-1] ? '0 : {1'b0, w_pow2};
        hi2_d = 1'b0;
      end
      default: hi2_d = 1'b0;
    endcase
  end

  // ----------------------------------------------- stage 2: partial products
  logic signed [PPL_W-1:0] w_ma_l, w_mb_l, ppl3_d;
  logic signed [PPH_W-1:0] w_ma_h, w_mb_h, pph3_d;

  assign w_ma_l = {{(PPL_W-MW){ma2_q[MW-1]}}, ma2_q};
  assign w_mb_l = {{(PPL_W-SPL){1'b0}}, mb2_q[SPL-1:0]};
  assign w_ma_h = {{(PPH_W-MW){ma2_q[MW-1]}}, ma2_q};
  assign w_mb_h = {{(PPH_W-SPH){mb2_q[MW-1]}}, mb2_q[MW-1:SPL]};
  assign ppl3_d = w_ma_l * w_mb_l;
  assign pph3_d = w_ma_h * w_mb_h;

  // -------------------------------------------------------- stage 3: sum
  logic [PW-1:0] prod4_d;
  assign prod4_d = {{(PW-PPL_W){ppl3_q[PPL_W-1]}}, ppl3_q}
                 + ({{(PW-PPH_W){pph3_q[PPH_W-1]}}, pph3_q} << SPL);

  // ------------------------------------------------- stage 4: word select
  logic [ALU_W-1:0] res5_d;
  assign res5_d = !sel4_q ? '0 :
                  hi4_q   ? prod4_q[2*ALU_W-1:ALU_W] : prod4_q[ALU_W-1:0];

  // ------------------------------------------------------ stage 5: flags
  // phi5_q holds every product bit above the low word, so signed overflow is
  // "not all equal to the result sign" and unsigned overflow is "nonzero".
  logic             w_ovf;
  logic [FLG_W-1:0] flg6_d;
  assign w_ovf = (op5_q == OP_MUL_LO) &&
                 (ext5_q ? (phi5_q != {(ALU_W+2){res5_q[ALU_W-1]}})
                         : (phi5_q != '0));

  always_comb begin
    flg6_d = '0;
    if (sel5_q) begin
      flg6_d[0] = (res5_q == '0);
      flg6_d[1] = res5_q[ALU_W-1];
      flg6_d[2] = w_ovf;
    end
  end

  // ------------------------------------------------------------ pipeline
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a1_q    <= '0;  b1_q   <= '0;
      op1_q   <= '0;  op2_q  <= '0;  op3_q  <= '0;  op4_q  <= '0;  op5_q  <= '0;
      ext1_q  <= 1'b0; ext2_q <= 1'b0; ext3_q <= 1'b0; ext4_q <= 1'b0; ext5_q <= 1'b0;
      sel1_q  <= 1'b0; sel2_q <= 1'b0; sel3_q <= 1'b0; sel4_q <= 1'b0; sel5_q <= 1'b0;
      hi2_q   <= 1'b0; hi3_q  <= 1'b0; hi4_q  <= 1'b0;
      ma2_q   <= '0;  mb2_q  <= '0;
      ppl3_q  <= '0;  pph3_q <= '0;
      prod4_q <= '0;
      res5_q  <= '0;  phi5_q <= '0;
      flg6_q  <= '0;
    end else begin
      a1_q    <= a_i;      b1_q   <= b_i;
      op1_q   <= op_i;     ext1_q <= ext_i;   sel1_q <= ms_sel_i;
      ma2_q   <= ma2_d;    mb2_q  <= mb2_d;   hi2_q  <= hi2_d;
      op2_q   <= op1_q;    ext2_q <= ext1_q;  sel2_q <= sel1_q;
      ppl3_q  <= ppl3_d;   pph3_q <= pph3_d;  hi3_q  <= hi2_q;
      op3_q   <= op2_q;    ext3_q <= ext2_q;  sel3_q <= sel2_q;
      prod4_q <= prod4_d;  hi4_q  <= hi3_q;
      op4_q   <= op3_q;    ext4_q <= ext3_q;  sel4_q <= sel3_q;
      res5_q  <= res5_d;   phi5_q <= prod4_q[PW-1:ALU_W];
      op5_q   <= op4_q;    ext5_q <= ext4_q;  sel5_q <= sel4_q;
      flg6_q  <= flg6_d;
    end
  end

  assign res_ms_5_o = res5_q;
  assign vld_5_o    = sel5_q;
  assign flg_ms_6_o = flg6_q;

endmodule
`default_nettype wire

// File: tb/tb_hive_alu_mult_shift.sv
`default_nettype none
// ============================================================================
// Module   : tb_hive_alu_mult_shift
// Purpose  : Directed self-checking bench for hive_alu_mult_shift with
//            hand-computed expected results and flags.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hive_alu_mult_shift;

  localparam logic [1:0] MUL_LO = 2'b00;
  localparam logic [1:0] MUL_HI = 2'b01;
  localparam logic [1:0] SHIFT  = 2'b10;
  localparam logic [1:0] POW    = 2'b11;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        ms_sel_i;
  logic [1:0]  op_i;
  logic        ext_i;
  logic [31:0] a_i, b_i;
  logic [31:0] res_ms_5_o;
  logic [3:0]  flg_ms_6_o;
  logic        vld_5_o;

  int n_tests = 0;
  int n_fail  = 0;

  hive_alu_mult_shift #(.ALU_W(32), .FLG_W(4), .SA_W(6)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .ms_sel_i   (ms_sel_i),
    .op_i       (op_i),
    .ext_i      (ext_i),
    .a_i        (a_i),
    .b_i        (b_i),
    .res_ms_5_o (res_ms_5_o),
    .flg_ms_6_o (flg_ms_6_o),
    .vld_5_o    (vld_5_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".res"}, res_ms_5_o, 32'h0);
    chk({tag, ".vld"}, {31'd0, vld_5_o}, 32'h0);
    chk({tag, ".flg"}, {28'd0, flg_ms_6_o}, 32'h0);
  endtask

  task automatic drive(input logic sel, input logic [1:0] op, input logic ext,
                       input logic [31:0] a, input logic [31:0] b);
    ms_sel_i = sel; op_i = op; ext_i = ext; a_i = a; b_i = b;
  endtask

  // Issue one op, then check result/valid at N+5 and flags at N+6.
  task automatic run_op(input string tag, input logic [1:0] op, input logic ext,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic [3:0] ef);
    drive(1'b1, op, ext, a, b);
    @(posedge clk_i); #1;
    drive(1'b0, MUL_LO, 1'b0, 32'h0, 32'h0);
    repeat (4) @(posedge clk_i);
    #1;
    chk({tag, ".res"}, res_ms_5_o, er);
    chk({tag, ".vld"}, {31'd0, vld_5_o}, 32'h1);
    @(posedge clk_i); #1;
    chk({tag, ".flg"}, {28'd0, flg_ms_6_o}, {28'd0, ef});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with an op presented: nothing may leak out.
    rst_i = 1'b1;
    drive(1'b1, POW, 1'b0, 32'h0, 32'd5);
    repeat (3) @(posedge clk_i);
    #1;
    chk_idle("reset");
    rst_i = 1'b0;
    drive(1'b0, MUL_LO, 1'b0, 32'h0, 32'h0);
    repeat (6) @(posedge clk_i);
    #1;
    chk_idle("post_reset");

    // Multiplies
    run_op("mullo_u_ovf", MUL_LO, 1'b0, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 4'b0110);
    run_op("mullo_s_noovf", MUL_LO, 1'b1, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 4'b0010);
    run_op("mullo_s_ovf", MUL_LO, 1'b1, 32'h4000_0000, 32'd2, 32'h8000_0000, 4'b0110);
    run_op("mullo_small", MUL_LO, 1'b0, 32'd3, 32'd7, 32'h0000_0015, 4'b0000);
    run_op("mullo_zero_ovf", MUL_LO, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0, 4'b0101);
    run_op("mulhi_s", MUL_HI, 1'b1, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF, 4'b0010);
    run_op("mulhi_u", MUL_HI, 1'b0, 32'h8000_0000, 32'd2, 32'h0000_0001, 4'b0000);
    run_op("mulhi_u_max", MUL_HI, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 4'b0010);
    run_op("mulhi_s_m1", MUL_HI, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 4'b0001);

    // Shifts
    run_op("sra4", SHIFT, 1'b1, 32'h8000_0010, 32'h0000_003C, 32'hF800_0001, 4'b0010);
    run_op("srl4", SHIFT, 1'b0, 32'h8000_0010, 32'h0000_003C, 32'h0800_0001, 4'b0000);
    run_op("sll4", SHIFT, 1'b1, 32'h8000_0010, 32'd4, 32'h0000_0100, 4'b0000);
    run_op("sra32", SHIFT, 1'b1, 32'h8000_0010, 32'h0000_0020, 32'hFFFF_FFFF, 4'b0010);
    run_op("srl32", SHIFT, 1'b0, 32'h8000_0010, 32'h0000_0020, 32'h0, 4'b0001);
    run_op("sll31", SHIFT, 1'b0, 32'h0000_0001, 32'd31, 32'h8000_0000, 4'b0010);

    // POW
    run_op("pow5", POW, 1'b0, 32'h0, 32'd5, 32'h0000_0020, 4'b0000);
    run_op("pow_neg", POW, 1'b0, 32'h0, 32'h0000_0020, 32'h0, 4'b0001);
    run_op("pow31", POW, 1'b1, 32'h0, 32'd31, 32'h8000_0000, 4'b0010);

    // Back-to-back issue
    drive(1'b1, MUL_LO, 1'b0, 32'd3, 32'd7);  @(posedge clk_i); #1;
    drive(1'b1, SHIFT,  1'b0, 32'd1, 32'd31); @(posedge clk_i); #1;
    drive(1'b1, POW,    1'b0, 32'd0, 32'd0);  @(posedge clk_i); #1;
    drive(1'b0, MUL_LO, 1'b0, 32'h0, 32'h0);
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    chk("b2b0.res", res_ms_5_o, 32'h0000_0015);
    chk("b2b0.vld", {31'd0, vld_5_o}, 32'h1);
    @(posedge clk_i); #1;
    chk("b2b1.res", res_ms_5_o, 32'h8000_0000);
    chk("b2b0.flg", {28'd0, flg_ms_6_o}, 32'h0);
    @(posedge clk_i); #1;
    chk("b2b2.res", res_ms_5_o, 32'h0000_0001);
    chk("b2b1.flg", {28'd0, flg_ms_6_o}, 32'h2);
    @(posedge clk_i); #1;
    chk("b2b_end.res", res_ms_5_o, 32'h0);
    chk("b2b_end.vld", {31'd0, vld_5_o}, 32'h0);
    chk("b2b2.flg", {28'd0, flg_ms_6_o}, 32'h0);
    repeat (3) @(posedge clk_i);

    // Asynchronous reset with ops in flight
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, POW, 1'b0, 32'h0, 32'(5 + i));
      @(posedge clk_i); #1;
    end
    drive(1'b0, MUL_LO, 1'b0, 32'h0, 32'h0);
    @(posedge clk_i); #1;
    chk("inflight.res", res_ms_5_o, 32'h0000_0020);
    #2;
    rst_i = 1'b1;
    #1;
    chk_idle("async_rst");
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk_i); #1;
      chk_idle("discard");
    end

    // Normal issue resumes
    run_op("resume", MUL_LO, 1'b0, 32'd6, 32'd7, 32'd42, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
